// File: rtl/s1_fetch_pkg.sv
// Shared constants for the stage-1 fetch block: reset PC, bubble encoding,
// PC region codes, RV32I opcodes and the region-to-source decode helper.
package s1_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h4000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   localparam logic [3:0] REGION_BIOS = 4'b0100;
   localparam logic [3:0] REGION_IMEM = 4'b0001;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
   localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_CSR       = 7'b1110011;

   typedef enum logic [1:0] {
      SRC_BIOS = 2'd0,
      SRC_IMEM = 2'd1,
      SRC_NONE = 2'd2
   } fetch_src_e;

   function automatic fetch_src_e region_src(input logic [3:0] region);
      fetch_src_e src;
      case (region)
         REGION_BIOS: src = SRC_BIOS;
         REGION_IMEM: src = SRC_IMEM;
         default:     src = SRC_NONE;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/s1_imm_j.sv
// Combinational J-type immediate decode with sign extension (bit 0 always 0).
module s1_imm_j (
   input  logic [31:12] inst,
   output logic [31:0]  imm_j
);

   assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/s1_fetch.sv
// Stage-1 fetch: owns the PC, addresses BIOS/IMEM, kills wrong-path words on
// redirect and registers pc/instruction/valid into stage 2.
// Optional in-fetch JAL prediction is enabled by defining S1_JAL_PREDICT_EN.
module s1_fetch
   import s1_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic [31:0] bios_dout,
   input  logic [31:0] imem_dout,
   output logic [31:0] fetch_addr,
   output logic [31:0] pc_s2,
   output logic [31:0] instruction_s2,
   output logic        valid_s2,
   output logic        jal_pred_s2
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_s2_q, pc_s2_d;
   logic [31:0] instruction_s2_q, instruction_s2_d;
   logic        valid_s2_q, valid_s2_d;
   logic        jal_pred_s2_q, jal_pred_s2_d;

   fetch_src_e  src;
   logic [31:0] inst_s1;
   logic        legal_s1;
   logic        jal_take;
   logic [31:0] jal_target;

   // Targets are word aligned; the low bits of redirect_target are dropped.
   logic unused_tgt_lo;
   assign unused_tgt_lo = ^redirect_target[1:0];

`ifdef S1_JAL_PREDICT_EN
   logic [31:0] imm_j;

   s1_imm_j u_imm_j (
      .inst  (inst_s1[31:12]),
      .imm_j (imm_j)
   );

   assign jal_take   = legal_s1 && (inst_s1[6:0] == OPC_JAL) && !stall && !redirect_valid;
   assign jal_target = pc_q + imm_j;
`else
   assign jal_take   = 1'b0;
   assign jal_target = 32'h0;
`endif

   always_comb begin
      src      = region_src(pc_q[31:28]);
      inst_s1  = NOP_INSTR;
      legal_s1 = 1'b0;
      case (src)
         SRC_BIOS: begin
            inst_s1  = bios_dout;
            legal_s1 = 1'b1;
         end
         SRC_IMEM: begin
            inst_s1  = imem_dout;
            legal_s1 = 1'b1;
         end
         default: ;
      endcase
   end

   // Stall beats redirect: stage 2 keeps presenting the redirect until stall drops.
   always_comb begin
      if (stall) begin
         pc_d = pc_q;
      end else if (redirect_valid) begin
         pc_d = {redirect_target[31:2], 2'b00};
      end else if (jal_take) begin
         pc_d = jal_target;
      end else begin
         pc_d = pc_q + 32'd4;
      end
      fetch_addr = rst ? pc_d : RESET_PC;
   end

   always_comb begin
      pc_s2_d          = pc_s2_q;
      instruction_s2_d = instruction_s2_q;
      valid_s2_d       = valid_s2_q;
      jal_pred_s2_d    = jal_pred_s2_q;
      if (!stall) begin
         pc_s2_d          = pc_q;
         instruction_s2_d = redirect_valid ? NOP_INSTR : inst_s1;
         valid_s2_d       = !redirect_valid && legal_s1;
         jal_pred_s2_d    = jal_take;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q             <= RESET_PC;
         pc_s2_q          <= 32'h0;
         instruction_s2_q <= NOP_INSTR;
         valid_s2_q       <= 1'b0;
         jal_pred_s2_q    <= 1'b0;
      end else begin
         pc_q             <= pc_d;
         pc_s2_q          <= pc_s2_d;
         instruction_s2_q <= instruction_s2_d;
         valid_s2_q       <= valid_s2_d;
         jal_pred_s2_q    <= jal_pred_s2_d;
      end
   end

   assign pc_s2          = pc_s2_q;
   assign instruction_s2 = instruction_s2_q;
   assign valid_s2       = valid_s2_q;
   assign jal_pred_s2    = jal_pred_s2_q;

endmodule

// File: tb/tb_s1_fetch.sv
// Directed plus random bench for s1_fetch: a reference model pushes the
// expected stage-2 state per cycle and the DUT output is popped and compared.
module tb_s1_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          W   = 66;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] bios_dout;
   logic [31:0] imem_dout;
   logic [31:0] fetch_addr;
   logic [31:0] pc_s2;
   logic [31:0] instruction_s2;
   logic        valid_s2;
   logic        jal_pred_s2;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_s2;
   logic [31:0]  m_pc;
   int           n_cmp;
   int           n_bad;

   s1_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .bios_dout       (bios_dout),
      .imem_dout       (imem_dout),
      .fetch_addr      (fetch_addr),
      .pc_s2           (pc_s2),
      .instruction_s2  (instruction_s2),
      .valid_s2        (valid_s2),
      .jal_pred_s2     (jal_pred_s2)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents: addi words tagged with the word index, one JAL +16 at 4000_0010.
   function automatic logic [31:0] bios_word(input logic [31:0] a);
      logic [31:0] w;
      if (a == 32'h4000_0010) w = 32'h0100_006F;
      else w = 32'h0000_0093 | ({22'h0, a[11:2]} << 20);
      return w;
   endfunction

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return 32'h0000_0113 | ({22'h0, a[11:2]} << 20);
   endfunction

   function automatic logic [31:0] jimm(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   always @(posedge clk) begin
      bios_dout <= bios_word(fetch_addr);
      imem_dout <= imem_word(fetch_addr);
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver + model: called at a falling edge, returns at the next falling edge
   task automatic step(input logic st, input logic rv, input logic [31:0] tgt);
      logic [31:0] inst;
      logic [31:0] nxt;
      logic        legal;
      logic        jal;
      stall           = st;
      redirect_valid  = rv;
      redirect_target = tgt;
      legal = 1'b1;
      if (m_pc[31:28] == 4'b0100) inst = bios_word(m_pc);
      else if (m_pc[31:28] == 4'b0001) inst = imem_word(m_pc);
      else begin
         inst  = NOP;
         legal = 1'b0;
      end
`ifdef S1_JAL_PREDICT_EN
      jal = legal && (inst[6:0] == 7'b1101111) && !st && !rv;
`else
      jal = 1'b0;
`endif
      if (st) nxt = m_pc;
      else if (rv) nxt = {tgt[31:2], 2'b00};
      else if (jal) nxt = m_pc + jimm(inst);
      else nxt = m_pc + 32'd4;
      #1;
      check("fetch_addr", {34'h0, fetch_addr}, {34'h0, nxt});
      if (!st) m_s2 = {m_pc, rv ? NOP : inst, !rv && legal, jal};
      exp_q.push_back(m_s2);
      m_pc = nxt;
      @(posedge clk);
      @(negedge clk);
      check("s2_state", {pc_s2, instruction_s2, valid_s2, jal_pred_s2}, exp_q.pop_front());
   endtask

   task automatic model_reset();
      m_pc = 32'h4000_0000;
      m_s2 = {32'h0, NOP, 1'b0, 1'b0};
   endtask

   initial begin
      logic [31:0] tgts[4];
      n_cmp = 0;
      n_bad = 0;
      tgts[0] = 32'h4000_0100;
      tgts[1] = 32'h1000_0042;
      tgts[2] = 32'h4000_0010;
      tgts[3] = 32'h3000_0000;

      rst             = 1'b0;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      @(negedge clk);
      @(negedge clk);
      check("rst_fetch_addr", {34'h0, fetch_addr}, {34'h0, 32'h4000_0000});
      check("rst_s2", {pc_s2, instruction_s2, valid_s2, jal_pred_s2}, {32'h0, NOP, 1'b0, 1'b0});

      // release: first word is already on bios_dout, no bubble
      rst = 1'b1;
      model_reset();
      step(1'b0, 1'b0, 32'h0);
      check("first_instr", {34'h0, instruction_s2}, {34'h0, 32'h0000_0093});
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      check("straight_pc", {34'h0, pc_s2}, {34'h0, 32'h4000_000C});

      // JAL +16 sits at 4000_0010
      step(1'b0, 1'b0, 32'h0);
`ifdef S1_JAL_PREDICT_EN
      check("jal_pred", {65'h0, jal_pred_s2}, {65'h0, 1'b1});
`else
      check("jal_pred", {65'h0, jal_pred_s2}, {65'h0, 1'b0});
`endif
      step(1'b0, 1'b0, 32'h0);

      // redirect with misaligned target, one bubble then target word
      step(1'b0, 1'b1, 32'h1000_0102);
      check("redir_bubble", {pc_s2[0], instruction_s2, valid_s2}, {pc_s2[0], NOP, 1'b0});
      step(1'b0, 1'b0, 32'h0);
      check("redir_target", {34'h0, pc_s2}, {34'h0, 32'h1000_0100});

      // stall with pending redirect, then redirect taken on release
      step(1'b1, 1'b1, 32'h4000_0040);
      step(1'b1, 1'b1, 32'h4000_0040);
      step(1'b1, 1'b1, 32'h4000_0040);
      step(1'b0, 1'b1, 32'h4000_0040);
      step(1'b0, 1'b0, 32'h0);

      // illegal region, then wrap from FFFF_FFFC
      step(1'b0, 1'b1, 32'h2000_0000);
      step(1'b0, 1'b0, 32'h0);
      check("illegal_valid", {65'h0, valid_s2}, {65'h0, 1'b0});
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);

      // back-to-back redirects, latest target wins
      step(1'b0, 1'b1, 32'h1000_0010);
      step(1'b0, 1'b1, 32'h4000_0080);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);

      for (int i = 0; i < 40; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, tgts[$urandom_range(0, 3)]);
      end

      // reset during stall and redirect
      rst             = 1'b0;
      stall           = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h1000_0000;
      #1;
      check("midrst_fetch", {34'h0, fetch_addr}, {34'h0, 32'h4000_0000});
      @(posedge clk);
      @(negedge clk);
      check("midrst_s2", {pc_s2, instruction_s2, valid_s2, jal_pred_s2}, {32'h0, NOP, 1'b0, 1'b0});
      rst = 1'b1;
      model_reset();
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
